// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM state encoding, default tick divider and
// counter full-scale values used by the controller and the counter chain.
package stopwatch_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RUNNING  = 2'd1;
  localparam logic [1:0] ST_PAUSED   = 2'd2;
  localparam logic [1:0] ST_OVERFLOW = 2'd3;

  typedef enum logic [1:0] {
    StIdle     = ST_IDLE,
    StRunning  = ST_RUNNING,
    StPaused   = ST_PAUSED,
    StOverflow = ST_OVERFLOW
  } sw_state_e;

  // 1 Hz tick from a 100 MHz system clock
  localparam int unsigned DEFAULT_TICK_DIV = 100_000_000;

  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;

endpackage

// File: rtl/stopwatch_ctrl_tick_prescaler.sv
// Count-tick prescaler: counts clk cycles while run is high, wraps at TICK_DIV-1
// and flags the terminal count. Holds its value while run is low so a paused
// second keeps its elapsed fraction.
module tick_prescaler
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tc
);

  localparam int unsigned PRESC_W = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0] TERM = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0] cnt_q;

  // Prescaler counter with synchronous reset/clear and wrap at terminal count
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tc = (cnt_q == TERM);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run-control sequencer: start/stop/clear FSM, 1 Hz count enable,
// counter clear, minutes enable and full-scale overflow flag.
// Optional lap-hold feature enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_req,
  input  logic       stop_req,
  input  logic       clear_req,
`ifdef STOPWATCH_LAP_EN
  input  logic       lap_req,
  output logic       lap_hold,
`endif
  input  logic       sec_rollover,
  input  logic       min_rollover,
  output logic       tick_en,
  output logic       min_en,
  output logic       count_clr,
  output logic [1:0] state,
  output logic       overflow
);

  sw_state_e state_q;
  logic      overflow_q;
  logic      count_clr_q;
  logic      rst_tail_q;  // stretches count_clr one cycle past reset
  logic      presc_tc;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (state_q == StRunning),
    .clr  (clear_req),
    .tc   (presc_tc)
  );

  // Count enables; rollover inputs only ever qualify min_en, never tick_en
  always_comb begin
    tick_en = (state_q == StRunning) && presc_tc && !clear_req && !stop_req;
    min_en  = tick_en && sec_rollover;
  end

  // Run-control FSM with registered clear and overflow outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      overflow_q  <= 1'b0;
      count_clr_q <= 1'b1;
      rst_tail_q  <= 1'b1;
    end else begin
      rst_tail_q  <= 1'b0;
      count_clr_q <= clear_req | rst_tail_q;
      overflow_q  <= 1'b0;
      if (clear_req) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_req) state_q <= StRunning;
          end
          StRunning: begin
            // min_en implies no stop_req, so these are mutually exclusive
            if (min_en && min_rollover) begin
              state_q    <= StOverflow;
              overflow_q <= 1'b1;
            end else if (stop_req) begin
              state_q <= StPaused;
            end
          end
          StPaused: begin
            if (start_req) state_q <= StRunning;
          end
          StOverflow: begin
            overflow_q <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic lap_hold_q;

  // Lap hold toggles only in RUNNING, below start/stop in priority
  always_ff @(posedge clk) begin
    if (!rst_n || clear_req) begin
      lap_hold_q <= 1'b0;
    end else if (state_q == StRunning) begin
      if (min_en && min_rollover) begin
        lap_hold_q <= 1'b0;
      end else if (!stop_req && !start_req && lap_req) begin
        lap_hold_q <= ~lap_hold_q;
      end
    end
  end

  assign lap_hold = lap_hold_q;
`endif

  assign state     = state_q;
  assign overflow  = overflow_q;
  assign count_clr = count_clr_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4 and a behavioural
// seconds/minutes counter chain (with preload) behind the controller.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_req = 1'b0;
  logic       stop_req = 1'b0;
  logic       clear_req = 1'b0;
  logic       sec_rollover;
  logic       min_rollover;
  logic       tick_en;
  logic       min_en;
  logic       count_clr;
  logic [1:0] state;
  logic       overflow;
`ifdef STOPWATCH_LAP_EN
  logic       lap_req = 1'b0;
  logic       lap_hold;
`endif

  logic [5:0] sec = 6'd0;
  logic [5:0] min = 6'd0;
  logic       pl_en = 1'b0;
  logic [5:0] pl_sec = 6'd0;
  logic [5:0] pl_min = 6'd0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .TICK_DIV(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_req   (start_req),
    .stop_req    (stop_req),
    .clear_req   (clear_req),
`ifdef STOPWATCH_LAP_EN
    .lap_req     (lap_req),
    .lap_hold    (lap_hold),
`endif
    .sec_rollover(sec_rollover),
    .min_rollover(min_rollover),
    .tick_en     (tick_en),
    .min_en      (min_en),
    .count_clr   (count_clr),
    .state       (state),
    .overflow    (overflow)
  );

  // Counter chain model
  assign sec_rollover = tick_en && (sec == 6'd59);
  assign min_rollover = min_en && (min == 6'd59);

  always @(posedge clk) begin
    if (count_clr) begin
      sec <= 6'd0;
      min <= 6'd0;
    end else if (pl_en) begin
      sec <= pl_sec;
      min <= pl_min;
    end else begin
      if (tick_en) sec <= sec_rollover ? 6'd0 : sec + 6'd1;
      if (min_en)  min <= min_rollover ? 6'd0 : min + 6'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then release all single-cycle pulses
  task automatic step();
    @(posedge clk);
    #1;
    start_req = 1'b0;
    stop_req  = 1'b0;
    clear_req = 1'b0;
    pl_en     = 1'b0;
`ifdef STOPWATCH_LAP_EN
    lap_req   = 1'b0;
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] tick_mask;
    int          pause_ticks;

    // Reset
    step();
    step();
    #1;
    chk("rst_state", state, 2'd0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_count_clr", count_clr, 1'b1);
    chk("rst_tick_en", tick_en, 1'b0);
    chk("rst_min_en", min_en, 1'b0);
    rst_n = 1'b1;
    step();
    chk("rst_count_clr_tail", count_clr, 1'b1);
    step();
    chk("rst_count_clr_done", count_clr, 1'b0);

    // Start at cycle 0, ticks at cycles 4, 8, 12
    start_req = 1'b1;
    step();
    chk("start_state", state, 2'd1);
    tick_mask = '0;
    for (int c = 1; c <= 12; c++) begin
      #1;
      tick_mask[c-1] = tick_en;
      step();
    end
    chk("tick_pattern", tick_mask, 12'b1000_1000_1000);
    chk("sec_after_3", sec, 6'd3);

    // Pause with prescaler=2, wait, resume: tick on first cycle after resume edge
    step();
    step();
    stop_req = 1'b1;
    #1;
    chk("stop_cycle_tick", tick_en, 1'b0);
    step();
    chk("paused_state", state, 2'd2);
    pause_ticks = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (tick_en) pause_ticks++;
      step();
    end
    chk("paused_ticks", pause_ticks, 0);
    chk("paused_sec", sec, 6'd3);
    start_req = 1'b1;
    step();
    chk("resume_state", state, 2'd1);
    chk("resume_tick", tick_en, 1'b1);
    step();
    chk("resume_sec", sec, 6'd4);
    chk("resume_no_tick", tick_en, 1'b0);

    // Stop + clear together at terminal count
    step();
    step();
    step();
    stop_req  = 1'b1;
    clear_req = 1'b1;
    #1;
    chk("clr_stop_tick", tick_en, 1'b0);
    step();
    chk("clr_state", state, 2'd0);
    chk("clr_count_clr", count_clr, 1'b1);
    step();
    chk("clr_count_clr_pulse", count_clr, 1'b0);
    chk("clr_sec", sec, 6'd0);

    // 03:59 -> 04:00
    pl_en     = 1'b1;
    pl_sec    = 6'd59;
    pl_min    = 6'd3;
    start_req = 1'b1;
    step();
    step();
    step();
    step();
    #1;
    chk("min_tick_en", tick_en, 1'b1);
    chk("min_en", min_en, 1'b1);
    step();
    chk("min_sec", sec, 6'd0);
    chk("min_min", min, 6'd4);
    chk("min_overflow", overflow, 1'b0);
    chk("min_state", state, 2'd1);

    // 59:59 -> 00:00 overflow
    pl_en  = 1'b1;
    pl_sec = 6'd59;
    pl_min = 6'd59;
    step();
    step();
    step();
    #1;
    chk("ovf_min_en", min_en, 1'b1);
    step();
    chk("ovf_state", state, 2'd3);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_sec", sec, 6'd0);
    chk("ovf_min", min, 6'd0);
    start_req = 1'b1;
    step();
    chk("ovf_start_ignored", state, 2'd3);
    stop_req = 1'b1;
    step();
    chk("ovf_stop_ignored", state, 2'd3);
    chk("ovf_no_tick", tick_en, 1'b0);
    clear_req = 1'b1;
    step();
    chk("ovf_clr_state", state, 2'd0);
    chk("ovf_clr_flag", overflow, 1'b0);

`ifdef STOPWATCH_LAP_EN
    // Lap hold toggling while counting continues
    step();
    start_req = 1'b1;
    step();
    step();
    step();
    step();
    chk("lap_tick4", tick_en, 1'b1);
    chk("lap_hold_init", lap_hold, 1'b0);
    step();
    lap_req = 1'b1;
    step();
    chk("lap_hold_set", lap_hold, 1'b1);
    step();
    step();
    chk("lap_tick8", tick_en, 1'b1);
    lap_req = 1'b1;
    step();
    chk("lap_hold_clr", lap_hold, 1'b0);
    lap_req = 1'b1;
    step();
    chk("lap_hold_reset", lap_hold, 1'b1);
    clear_req = 1'b1;
    step();
    chk("lap_hold_clear_req", lap_hold, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Run-control sequencer for the stopwatch timekeeping datapath (seconds counter, minutes counter).
- Decodes start/stop/clear requests into a 4-state FSM.
- Generates the 1 Hz count-enable tick from the system clock.
- Issues the synchronous clear and forwards seconds rollover as the minutes enable.
- Flags full-scale overflow (59:59 -> 00:00).
- Sits between the debounced button logic and the counter chain.

Parameters:
TICK_DIV, 100000000, clk cycles per count tick; legal range >= 2.
PRESC_W, $clog2(TICK_DIV), prescaler counter width (derived; not overridden).

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
start_req  input  1  single-cycle pulse, start/resume
stop_req  input  1  single-cycle pulse, pause
clear_req  input  1  single-cycle pulse, zero the stopwatch
sec_rollover  input  1  seconds counter rollover (enabled AND seconds==59), combinational from counter
min_rollover  input  1  minutes counter rollover (enabled AND minutes==59), combinational from counter
tick_en  output  1  enable to seconds counter, one-cycle pulse
min_en  output  1  enable to minutes counter
count_clr  output  1  one-cycle clear to both counters (drives their reset path)
state  output  2  FSM state: 0 IDLE, 1 RUNNING, 2 PAUSED, 3 OVERFLOW
overflow  output  1  high while state==OVERFLOW

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, prescaler=0, count_clr=1 for that cycle and the next, overflow=0. tick_en=0 and min_en=0 throughout reset.
- Request priority, same cycle: clear_req > stop_req > start_req.
- clear_req, any state: next state IDLE, prescaler<=0, count_clr=1 for exactly one cycle. count_clr is registered and asserts the cycle after clear_req.
- IDLE: start_req -> RUNNING. stop_req ignored.
- RUNNING:
  - stop_req -> PAUSED.
  - start_req ignored.
  - Prescaler increments every cycle and wraps TICK_DIV-1 -> 0.
- PAUSED:
  - start_req -> RUNNING.
  - Prescaler holds its value, so a resumed second keeps its elapsed fraction.
  - stop_req ignored.
- OVERFLOW:
  - Entered from RUNNING when min_en && min_rollover, i.e. the counters wrap to 00:00 that edge.
  - start_req and stop_req ignored.
  - Only clear_req or reset exits.
- tick_en: combinational = (state==RUNNING) && (prescaler==TICK_DIV-1) && !clear_req && !stop_req.
  - A stop coinciding with the terminal prescaler count suppresses that tick.
  - First tick occurs TICK_DIV cycles after the RUNNING entry edge.
- min_en: combinational = tick_en && sec_rollover.
- Combinational loop guard: sec_rollover and min_rollover are consumed only ANDed with tick_en/min_en. No path from them back into tick_en.
- overflow: registered, equals (state==OVERFLOW).
- All outputs and internal state update only on clk rising edge. No asynchronous behaviour.

Optional Feature:
STOPWATCH_LAP_EN
- Defined: adds input lap_req (pulse) and output lap_hold (1).
  - In RUNNING, lap_req toggles lap_hold. The display layer freezes its shown value while lap_hold=1; counting continues.
  - lap_hold clears on clear_req, on reset, and on entry to OVERFLOW.
  - lap_req is ignored in IDLE/PAUSED/OVERFLOW.
  - lap_req has the lowest priority after start_req.
- Undefined: lap_req and lap_hold ports do not exist. Behaviour otherwise identical.

Decomposition:
- stopwatch_pkg:
  - state encoding constants ST_IDLE/ST_RUNNING/ST_PAUSED/ST_OVERFLOW.
  - Default TICK_DIV.
  - SEC_MAX=59, MIN_MAX=59 shared with the counters.
- Sub-module tick_prescaler:
  - Inputs: clk, rst_n, run, clr.
  - Output: prescaler terminal-count flag.
  - Parameter TICK_DIV.
  - Instantiated once. FSM stays in stopwatch_ctrl.

Test Plan (TICK_DIV=4, counters instantiated behind the controller):
- Reset then start_req at cycle 0 -> state=1 next edge; tick_en pulses at cycles 4, 8, 12; seconds reads 3 after cycle 12.
- Run, stop_req with prescaler=2, wait 20 cycles, start_req -> no ticks while PAUSED; next tick exactly 1 cycle after resume edge+1 (remaining fraction kept).
- stop_req and clear_req same cycle in RUNNING -> state=IDLE, count_clr=1 one cycle, seconds=0, no tick_en that cycle.
- Preload seconds=59, minutes=3, run to tick -> min_en=1 same cycle as tick_en; result 04:00; overflow=0.
- Preload 59:59, run to tick -> counters 00:00, state=3, overflow=1; start_req ignored; clear_req -> state=0, overflow=0.
- STOPWATCH_LAP_EN defined: lap_req at cycle 5 -> lap_hold=1 while ticks continue; lap_req again -> 0; clear_req with lap_hold=1 -> lap_hold=0.
